// File: rtl/video_stream_receiver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_stream_receiver_if : Avalon-ST pixel stream plus frame buffer write port.
// Rev 1.0
// ---------------------------------------------------------------------------
interface video_stream_receiver_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
);
  logic [DATA_W-1:0] sink_data;
  logic              sink_startofpacket;
  logic              sink_endofpacket;
  logic              sink_valid;
  logic              sink_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output sink_data, sink_startofpacket, sink_endofpacket, sink_valid, wr_stall,
    input  sink_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  sink_data, sink_startofpacket, sink_endofpacket, sink_valid, wr_stall,
    output sink_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/video_stream_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_stream_receiver : Avalon-ST video sink writing pixels linearly to a frame buffer.
// Rev 1.0
// ---------------------------------------------------------------------------
module video_stream_receiver #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
) (
  input  wire logic               clock,
  input  wire logic               reset,
  video_stream_receiver_if.slave  bus,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic                    err_short,
  output logic                    err_long
);

  localparam logic [ADDR_W-1:0] C_LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VIDEO = 2'd1,
    S_SKIP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic              r_err_short;
  logic              r_err_long;

  logic              w_ready;
  logic              w_accept;
  logic              w_sop;
  logic              w_eop;

  assign w_ready  = ~reset & ~bus.wr_stall;
  assign w_accept = bus.sink_valid & w_ready;
  assign w_sop    = bus.sink_startofpacket;
  assign w_eop    = bus.sink_endofpacket;

  assign bus.sink_ready = w_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign frame_done     = r_frame_done;
  assign frame_count    = r_frame_count;
  assign err_short      = r_err_short;
  assign err_long       = r_err_long;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (w_sop) begin
          // A header always restarts parsing, whatever packet was in flight.
          if (r_state == S_VIDEO) r_err_short <= 1'b1;
          if (r_state == S_DRAIN) r_err_long  <= 1'b1;
          if (bus.sink_data[3:0] == 4'd0) begin
            r_pix_cnt <= '0;
            if (w_eop) begin
              r_err_short <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state     <= S_VIDEO;
            end
          end else begin
            r_state <= w_eop ? S_IDLE : S_SKIP;
          end
        end else begin
          case (r_state)
            S_VIDEO: begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_pix_cnt;
              r_wr_data <= bus.sink_data;
              if (r_pix_cnt == C_LAST_PIX) begin
                if (w_eop) begin
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
                  r_state       <= S_IDLE;
                end else begin
                  r_state       <= S_DRAIN;
                end
              end else if (w_eop) begin
                r_err_short <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_pix_cnt   <= r_pix_cnt + 1'b1;
              end
            end
            S_SKIP: begin
              if (w_eop) r_state <= S_IDLE;
            end
            S_DRAIN: begin
              r_err_long <= 1'b1;
              if (w_eop) r_state <= S_IDLE;
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_stream_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_video_stream_receiver : directed vector bench for video_stream_receiver (4x2 frame).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_video_stream_receiver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_stream_receiver_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_short;
  logic        err_long;

  video_stream_receiver #(
    .WIDTH (4),
    .HEIGHT(2),
    .DATA_W(16),
    .ADDR_W(3)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic        sop;
    logic        eop;
    logic        stall;
    logic [15:0] d;
    logic        ew;
    logic [2:0]  ea;
    logic        done;
    logic        es;
    logic        el;
    logic [15:0] fc;
  } vec_t;

  vec_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          vec_no   = 0;
  logic        x_es;
  logic        x_el;
  logic [15:0] x_fc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, vec_no, got, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic s, input logic e,
                              input logic st, input logic [15:0] d, input logic ew,
                              input logic [2:0] ea, input logic dn);
    vec_t t;
    t.rst = r;  t.v = v;   t.sop = s;  t.eop = e;  t.stall = st; t.d = d;
    t.ew = ew;  t.ea = ea; t.done = dn;
    t.es = x_es; t.el = x_el; t.fc = x_fc;
    q.push_back(t);
  endfunction

  function automatic void do_rst();
    x_es = 1'b0; x_el = 1'b0; x_fc = 16'd0;
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
  endfunction
  function automatic void hdr(input logic [15:0] d, input logic e);
    add(1'b0, 1'b1, 1'b1, e, 1'b0, d, 1'b0, 3'd0, 1'b0);
  endfunction
  function automatic void pix(input logic [15:0] d, input logic e, input logic [2:0] a, input logic dn);
    add(1'b0, 1'b1, 1'b0, e, 1'b0, d, 1'b1, a, dn);
  endfunction
  function automatic void drop(input logic [15:0] d, input logic e);
    add(1'b0, 1'b1, 1'b0, e, 1'b0, d, 1'b0, 3'd0, 1'b0);
  endfunction
  function automatic void stalled(input logic [15:0] d);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, d, 1'b0, 3'd0, 1'b0);
  endfunction
  function automatic void gap();
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b0, 3'd0, 1'b0);
  endfunction

  // Good 8-pixel frame starting from a header; frame_count expected to step on the last pixel.
  function automatic void good_frame(input logic [15:0] base);
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) x_fc = x_fc + 16'd1;
      pix(base + 16'(i), (i == 7), 3'(i), (i == 7));
    end
  endfunction

  task automatic run_q();
    for (int i = 0; i < q.size(); i++) begin
      vec_no++;
      rst                    = q[i].rst;
      bus.sink_valid         = q[i].v;
      bus.sink_startofpacket = q[i].sop;
      bus.sink_endofpacket   = q[i].eop;
      bus.sink_data          = q[i].d;
      bus.wr_stall           = q[i].stall;
      #1;
      chk("sink_ready", {31'd0, bus.sink_ready}, {31'd0, !(q[i].rst || q[i].stall)});
      @(posedge clk);
      #1;
      chk("wr_en", {31'd0, bus.wr_en}, {31'd0, q[i].ew});
      if (q[i].ew || q[i].rst) begin
        chk("wr_addr", {29'd0, bus.wr_addr}, {29'd0, q[i].ea});
        chk("wr_data", {16'd0, bus.wr_data}, {16'd0, q[i].d});
      end
      chk("frame_done",  {31'd0, frame_done},  {31'd0, q[i].done});
      chk("err_short",   {31'd0, err_short},   {31'd0, q[i].es});
      chk("err_long",    {31'd0, err_long},    {31'd0, q[i].el});
      chk("frame_count", {16'd0, frame_count}, {16'd0, q[i].fc});
    end
    q.delete();
  endtask

  initial begin
    rst                    = 1'b1;
    bus.sink_valid         = 1'b0;
    bus.sink_startofpacket = 1'b0;
    bus.sink_endofpacket   = 1'b0;
    bus.sink_data          = 16'h0000;
    bus.wr_stall           = 1'b0;
    x_es = 1'b0; x_el = 1'b0; x_fc = 16'd0;
    @(posedge clk);
    #1;

    // 1: clean frame, valid every cycle
    do_rst();
    good_frame(16'h1000);

    // 2: same frame under alternating stall and valid gaps
    do_rst();
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      stalled(16'h1000 + 16'(i));
      if (i % 3 == 0) gap();
      if (i == 7) x_fc = x_fc + 16'd1;
      pix(16'h1000 + 16'(i), (i == 7), 3'(i), (i == 7));
    end

    // 3: control packet skipped, then a video frame
    do_rst();
    hdr(16'h000F, 1'b0);
    drop(16'hAAA0, 1'b0);
    drop(16'hAAA1, 1'b0);
    drop(16'hAAA2, 1'b1);
    gap();
    good_frame(16'h1100);

    // 4: short frame then good frame
    do_rst();
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) x_es = 1'b1;
      pix(16'h2000 + 16'(i), (i == 4), 3'(i), 1'b0);
    end
    good_frame(16'h2100);

    // 5: long frame drained, then sop mid-frame restarts at address 0
    do_rst();
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) pix(16'h3000 + 16'(i), 1'b0, 3'(i), 1'b0);
    x_el = 1'b1;
    drop(16'h3008, 1'b0);
    drop(16'h3009, 1'b1);
    drop(16'h300A, 1'b0);
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) pix(16'h4000 + 16'(i), 1'b0, 3'(i), 1'b0);
    x_es = 1'b1;
    good_frame(16'h5000);
    run_q();

    // 6: reset in the middle of a frame, with sticky state from test 5 still set
    hdr(16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) pix(16'h6000 + 16'(i), 1'b0, 3'(i), 1'b0);
    run_q();
    vec_no++;
    rst                    = 1'b1;
    bus.sink_valid         = 1'b1;
    bus.sink_startofpacket = 1'b0;
    bus.sink_endofpacket   = 1'b0;
    bus.sink_data          = 16'h6004;
    bus.wr_stall           = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.sink_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_wr_en",       {31'd0, bus.wr_en},   32'd0);
    chk("rst_wr_addr",     {29'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data",     {16'd0, bus.wr_data}, 32'd0);
    chk("rst_frame_done",  {31'd0, frame_done},  32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_err_short",   {31'd0, err_short},   32'd0);
    chk("rst_err_long",    {31'd0, err_long},    32'd0);
    x_es = 1'b0; x_el = 1'b0; x_fc = 16'd0;
    drop(16'h6005, 1'b0);
    good_frame(16'h6100);

    // 7: single-beat packets: video sop+eop is a short frame, control sop+eop is silent
    do_rst();
    x_es = 1'b1;
    hdr(16'h0000, 1'b1);
    hdr(16'h0003, 1'b1);
    drop(16'h7000, 1'b0);
    good_frame(16'h7100);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
